// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - ARM condition codes, NZCV bit positions and flag-pending age constants
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [1:0] age_t;

    // Cycles a flag write stays invisible on cpsr_flags: write-enable edge plus CPSR output register.
    localparam age_t AGE_RELOAD = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator, shared with the branch unit
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_stage.sv
// rtl/cond_flag_stage.sv - condition check, NZCV generation and CPSR write with pending-flag tracking
// FLAG_FWD_EN: forward pending flags from the shadow copy instead of interlocking for two cycles.
module cond_flag_stage
    import cond_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_cond,
    input  logic                  in_set_flags,
    input  logic                  in_logical,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_carry,
    input  logic                  in_overflow,
    input  logic                  flush,
    input  logic [3:0]            cpsr_flags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_exec,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  cpsr_we,
    output logic [3:0]            cpsr_flagsin,
    output logic [3:0]            eff_flags
);

    logic [3:0] shadow;
    age_t       age;
    logic       pass;
    logic [3:0] new_flags;
    logic       accept;
    logic       flag_write;
    logic       slot_free;

    assign slot_free = !out_valid || out_ready;

`ifdef FLAG_FWD_EN
    assign in_ready = slot_free;
`else
    // Without forwarding, hold off until the CPSR output itself carries the last write.
    assign in_ready = slot_free && (age == '0);
`endif

    assign eff_flags = (age != '0) ? shadow : cpsr_flags;

    cond_eval u_cond_eval (
        .cond (in_cond),
        .nzcv (eff_flags),
        .pass (pass)
    );

    always_comb begin
        new_flags         = 4'b0000;
        new_flags[FLAG_N] = in_result[DATA_WIDTH-1];
        new_flags[FLAG_Z] = (in_result == '0);
        new_flags[FLAG_C] = in_carry;
        new_flags[FLAG_V] = in_logical ? eff_flags[FLAG_V] : in_overflow;
    end

    assign accept     = in_valid && in_ready && !flush;
    assign flag_write = accept && pass && in_set_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_exec     <= 1'b0;
            out_result   <= '0;
            cpsr_we      <= 1'b0;
            cpsr_flagsin <= 4'b0000;
            shadow       <= 4'b0000;
            age          <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_exec   <= pass;
                out_result <= in_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            cpsr_we <= flag_write;
            if (flag_write) begin
                cpsr_flagsin <= new_flags;
                shadow       <= new_flags;
                age          <= AGE_RELOAD;
            end else if (age != '0) begin
                age <= age - age_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_flag_stage.sv
// tb/tb_cond_flag_stage.sv - table-driven and sequence checks of cond_flag_stage against a CPSR model
module tb_cond_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cond = 4'd14;
    logic        in_set_flags = 1'b0;
    logic        in_logical = 1'b0;
    logic [31:0] in_result = 32'd0;
    logic        in_carry = 1'b0;
    logic        in_overflow = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  cpsr_flags;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_exec;
    logic [31:0] out_result;
    logic        cpsr_we;
    logic [3:0]  cpsr_flagsin;
    logic [3:0]  eff_flags;

    always #5 clk = ~clk;

    cond_flag_stage #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cond      (in_cond),
        .in_set_flags (in_set_flags),
        .in_logical   (in_logical),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .flush        (flush),
        .cpsr_flags   (cpsr_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_exec     (out_exec),
        .out_result   (out_result),
        .cpsr_we      (cpsr_we),
        .cpsr_flagsin (cpsr_flagsin),
        .eff_flags    (eff_flags)
    );

    // CPSR: write latch on the we edge, then an output register before bits [31:28] show it.
    logic [3:0] cpsr_int;
    logic [3:0] cpsr_out;
    logic       cpsr_load = 1'b1;
    logic [3:0] cpsr_load_val = 4'b0000;

    always @(posedge clk) begin
        if (cpsr_load) begin
            cpsr_int <= cpsr_load_val;
            cpsr_out <= cpsr_load_val;
        end else begin
            if (cpsr_we) cpsr_int <= cpsr_flagsin;
            cpsr_out <= cpsr_int;
        end
    end
    assign cpsr_flags = cpsr_out;

    typedef struct {
        logic [3:0]  cpsr;
        logic [3:0]  cond;
        logic        s;
        logic        l;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        exp_exec;
        logic        exp_we;
        logic [3:0]  exp_flags;
    } vec_t;

    typedef struct packed {
        logic        exec;
        logic [31:0] result;
    } exp_t;

    localparam int N_VEC = 21;
    vec_t vecs [N_VEC];
    exp_t sb [$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   we_seen = 0;
    logic exp_exec = 1'b0;

    function automatic vec_t mk(input logic [3:0] cpsr, input logic [3:0] cond, input logic s,
                                input logic l, input logic [31:0] res, input logic c, input logic v,
                                input logic ee, input logic ew, input logic [3:0] ef);
        vec_t r;
        r.cpsr = cpsr; r.cond = cond; r.s = s; r.l = l; r.res = res; r.c = c; r.v = v;
        r.exp_exec = ee; r.exp_we = ew; r.exp_flags = ef;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Called at a negedge with inputs already driven: monitor outputs, record accepts, advance one cycle.
    task automatic clk_cycle();
        exp_t e;
        #1;
        if (cpsr_we) we_seen++;
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_exec", 32'(out_exec), 32'(e.exec));
                check("out_result", out_result, e.result);
            end
        end
        if (in_valid && in_ready && !flush) sb.push_back('{exp_exec, in_result});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cpsr(input logic [3:0] val);
        cpsr_load = 1'b1;
        cpsr_load_val = val;
        clk_cycle();
        cpsr_load = 1'b0;
    endtask

    task automatic drive(input logic [3:0] cond, input logic s, input logic l,
                         input logic [31:0] res, input logic c, input logic v, input logic ee);
        in_valid = 1'b1;
        in_cond = cond; in_set_flags = s; in_logical = l;
        in_result = res; in_carry = c; in_overflow = v;
        exp_exec = ee;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    initial begin
        int  stalls;
        int  exp_stalls;
        logic accepted;

        vecs[0]  = mk(4'b0100, 4'd0,  0, 0, 32'h1,        0, 0, 1, 0, 4'b0000);
        vecs[1]  = mk(4'b0000, 4'd0,  0, 0, 32'h2,        0, 0, 0, 0, 4'b0000);
        vecs[2]  = mk(4'b0000, 4'd1,  0, 0, 32'h3,        0, 0, 1, 0, 4'b0000);
        vecs[3]  = mk(4'b0010, 4'd8,  0, 0, 32'h4,        0, 0, 1, 0, 4'b0000);
        vecs[4]  = mk(4'b0110, 4'd8,  0, 0, 32'h5,        0, 0, 0, 0, 4'b0000);
        vecs[5]  = mk(4'b1000, 4'd10, 0, 0, 32'h6,        0, 0, 0, 0, 4'b0000);
        vecs[6]  = mk(4'b1001, 4'd10, 0, 0, 32'h7,        0, 0, 1, 0, 4'b0000);
        vecs[7]  = mk(4'b1001, 4'd12, 0, 0, 32'h8,        0, 0, 1, 0, 4'b0000);
        vecs[8]  = mk(4'b1101, 4'd12, 0, 0, 32'h9,        0, 0, 0, 0, 4'b0000);
        vecs[9]  = mk(4'b0100, 4'd13, 0, 0, 32'hA,        0, 0, 1, 0, 4'b0000);
        vecs[10] = mk(4'b1111, 4'd15, 1, 0, 32'h0,        1, 0, 0, 0, 4'b0000);
        vecs[11] = mk(4'b0000, 4'd14, 1, 0, 32'h0,        1, 0, 1, 1, 4'b0110);
        vecs[12] = mk(4'b0000, 4'd14, 1, 0, 32'h80000000, 0, 1, 1, 1, 4'b1001);
        vecs[13] = mk(4'b0001, 4'd14, 1, 1, 32'h5,        1, 0, 1, 1, 4'b0011);
        vecs[14] = mk(4'b0000, 4'd0,  1, 0, 32'h0,        1, 0, 0, 0, 4'b0000);
        vecs[15] = mk(4'b0001, 4'd6,  1, 1, 32'h0,        0, 0, 1, 1, 4'b0101);
        vecs[16] = mk(4'b1000, 4'd11, 0, 0, 32'hB,        0, 0, 1, 0, 4'b0000);
        vecs[17] = mk(4'b0000, 4'd3,  0, 0, 32'hC,        0, 0, 1, 0, 4'b0000);
        vecs[18] = mk(4'b0010, 4'd9,  0, 0, 32'hD,        0, 0, 0, 0, 4'b0000);
        vecs[19] = mk(4'b0000, 4'd4,  0, 0, 32'hE,        0, 0, 0, 0, 4'b0000);
        vecs[20] = mk(4'b0001, 4'd7,  0, 0, 32'hF,        0, 0, 0, 0, 4'b0000);

`ifdef FLAG_FWD_EN
        exp_stalls = 0;
`else
        exp_stalls = 2;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_exec", 32'(out_exec), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_cpsr_we", 32'(cpsr_we), 32'd0);
        check("rst_flagsin", 32'(cpsr_flagsin), 32'd0);
        check("rst_eff", 32'(eff_flags), 32'd0);
        rst_n = 1'b1;
        cpsr_load = 1'b0;
        clk_cycle();

        // Table of isolated instructions
        for (int i = 0; i < N_VEC; i++) begin
            load_cpsr(vecs[i].cpsr);
            check($sformatf("v%0d_eff_idle", i), 32'(eff_flags), 32'(vecs[i].cpsr));
            drive(vecs[i].cond, vecs[i].s, vecs[i].l, vecs[i].res, vecs[i].c, vecs[i].v,
                  vecs[i].exp_exec);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            clk_cycle();
            in_valid = 1'b0;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_we", i), 32'(cpsr_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we)
                check($sformatf("v%0d_flagsin", i), 32'(cpsr_flagsin), 32'(vecs[i].exp_flags));
            clk_cycle();
            check($sformatf("v%0d_we_pulse", i), 32'(cpsr_we), 32'd0);
            idle(2);
            check($sformatf("v%0d_eff_after", i), 32'(eff_flags),
                  32'(vecs[i].exp_we ? vecs[i].exp_flags : vecs[i].cpsr));
        end

        // Back-to-back SUBS (Z=1) then BEQ
        load_cpsr(4'b0000);
        drive(4'd14, 1, 0, 32'h0, 1, 0, 1);
        clk_cycle();
        check("b2b_eff_fwd", 32'(eff_flags), 32'b0110);
        drive(4'd0, 0, 0, 32'h1234, 0, 0, 1);
        stalls = 0;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            #1;
            if (in_ready) accepted = 1'b1;
            else stalls++;
            clk_cycle();
        end
        check("b2b_accepted", 32'(accepted), 32'd1);
        check("b2b_stalls", stalls, exp_stalls);
        idle(4);

        // Flag-setter held in the output slot for three cycles
        load_cpsr(4'b0000);
        we_seen = 0;
        drive(4'd14, 1, 0, 32'h80000000, 0, 1, 1);
        clk_cycle();
        out_ready = 1'b0;
        drive(4'd14, 0, 0, 32'h7, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_result", out_result, 32'h80000000);
            check("stall_out_exec", 32'(out_exec), 32'd1);
            clk_cycle();
        end
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            #1;
            if (in_ready) accepted = 1'b1;
            clk_cycle();
        end
        check("stall_second_accepted", 32'(accepted), 32'd1);
        idle(4);
        check("stall_we_pulses", we_seen, 1);
        check("stall_eff_final", 32'(eff_flags), 32'b1001);

        // Flush coincident with ANDS result 0
        load_cpsr(4'b0000);
        flush = 1'b1;
        drive(4'd14, 1, 1, 32'h0, 1, 0, 1);
        clk_cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_we", 32'(cpsr_we), 32'd0);
            check("flush_eff", 32'(eff_flags), 32'd0);
            clk_cycle();
        end

        // Reset while a flag write is pending
        load_cpsr(4'b0000);
        drive(4'd14, 1, 0, 32'h0, 1, 0, 1);
        clk_cycle();
        in_valid = 1'b0;
        check("mrst_eff_pending", 32'(eff_flags), 32'b0110);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_we", 32'(cpsr_we), 32'd0);
        check("mrst_out_result", out_result, 32'd0);
        check("mrst_eff", 32'(eff_flags), 32'(cpsr_flags));
        sb.delete();
        clk_cycle();
        check("mrst_eff_next", 32'(eff_flags), 32'(cpsr_flags));
        check("mrst_cpsr_unwritten", 32'(cpsr_flags), 32'd0);
        rst_n = 1'b1;
        idle(2);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
